trng_postproc: RTL and testbench

- Sits directly downstream of the ring-oscillator entropy source and upstream of the TRNG key/status register interface.
- Consumes the sampled raw bit stream and applies a von Neumann debiaser.
- Runs a repetition-count health test on the raw bits.
- Packs debiased bits into N_BITS_KEY-wide keys and presents them with a ready/ack handshake and a one-cycle interrupt pulse.

---
 rtl/trng_postproc.sv | 164 ++++++++++++++++
 tb/tb_trng_postproc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_postproc.sv
// TRNG post-processing: von Neumann debiaser, repetition-count
// health test and key packing with a ready/ack holding register.
module trng_postproc #(
  parameter int N_BITS_KEY = 32,
  parameter int RCT_CUTOFF = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  raw_bit_i,
  input  logic                  raw_valid_i,
  input  logic                  ack_read_i,
  output logic [N_BITS_KEY-1:0] out_key_o,
  output logic                  key_ready_o,
  output logic                  intr_o,
  output logic                  health_fail_o
);

  localparam int CW = $clog2(N_BITS_KEY);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FAIL
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  pair_full_q;
  logic                  pair_first_q;
  logic                  prev_q;
  logic                  have_prev_q;
  logic [RW-1:0]         run_q;
  logic [RW-1:0]         run_d;
  logic [N_BITS_KEY-1:0] acc_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  stall_q;

  logic                  active;
  logic                  bit_in;
  logic                  rct_trip;
  logic                  db_valid;
  logic                  db_bit;
  logic                  last_bit;
  logic                  word_done;
  logic [N_BITS_KEY-1:0] word;

  // Datapath strobes for the current cycle.
  always_comb begin
    active   = (state_q == COLLECT) && enable_i;
    bit_in   = active && raw_valid_i;
    run_d    = RW'(1);
    if (have_prev_q && (raw_bit_i == prev_q)) begin
      if (run_q == RW'(RCT_CUTOFF))
        run_d = run_q;
      else
        run_d = run_q + RW'(1);
    end
    rct_trip  = bit_in && (run_d == RW'(RCT_CUTOFF));
    db_bit    = pair_first_q;
    db_valid  = bit_in && !rct_trip && pair_full_q &&
                (pair_first_q != raw_bit_i);
    last_bit  = (bit_cnt_q == CW'(N_BITS_KEY - 1));
    word_done = db_valid && !stall_q && last_bit;
    word      = {db_bit, acc_q[N_BITS_KEY-2:0]};
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; a low enable always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = COLLECT;
      COLLECT: if (rct_trip) state_d = FAIL;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    if (!enable_i)
      state_d = IDLE;
  end

  assign health_fail_o = (state_q == FAIL);

  // Debias, pack, hand off and health-track the raw stream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_key_o    <= '0;
      key_ready_o  <= 1'b0;
      intr_o       <= 1'b0;
      pair_full_q  <= 1'b0;
      pair_first_q <= 1'b0;
      prev_q       <= 1'b0;
      have_prev_q  <= 1'b0;
      run_q        <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      stall_q      <= 1'b0;
    end else if (!active) begin
      key_ready_o  <= 1'b0;
      intr_o       <= 1'b0;
      pair_full_q  <= 1'b0;
      pair_first_q <= 1'b0;
      prev_q       <= 1'b0;
      have_prev_q  <= 1'b0;
      run_q        <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      stall_q      <= 1'b0;
    end else if (rct_trip) begin
      key_ready_o <= 1'b0;
      intr_o      <= 1'b0;
      run_q       <= run_d;
    end else begin
      intr_o <= 1'b0;
      if (bit_in) begin
        prev_q      <= raw_bit_i;
        have_prev_q <= 1'b1;
        run_q       <= run_d;
        if (pair_full_q) begin
          pair_full_q <= 1'b0;
        end else begin
          pair_full_q  <= 1'b1;
          pair_first_q <= raw_bit_i;
        end
      end
      if (db_valid && !stall_q) begin
        if (last_bit) begin
          if (!key_ready_o || ack_read_i) begin
            out_key_o   <= word;
            key_ready_o <= 1'b1;
            intr_o      <= 1'b1;
            bit_cnt_q   <= '0;
          end else begin
            stall_q                <= 1'b1;
            acc_q[N_BITS_KEY-1]    <= db_bit;
          end
        end else begin
          acc_q[bit_cnt_q] <= db_bit;
          bit_cnt_q        <= bit_cnt_q + CW'(1);
        end
      end
      if (ack_read_i && key_ready_o && !word_done) begin
        if (stall_q) begin
          out_key_o <= acc_q;
          intr_o    <= 1'b1;
          stall_q   <= 1'b0;
          bit_cnt_q <= '0;
        end else begin
          key_ready_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_postproc.sv
// Scoreboard bench for trng_postproc: expected keys are queued
// when stimulus is driven and popped on each interrupt pulse.
module tb_trng_postproc;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         raw_bit = 1'b0;
  logic         raw_valid = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] out_key;
  logic         key_ready;
  logic         intr;
  logic         health_fail;

  int           n_checks = 0;
  int           n_pass = 0;
  int           intr_cnt = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] last_key;

  trng_postproc #(.N_BITS_KEY(N), .RCT_CUTOFF(31)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .raw_bit_i    (raw_bit),
    .raw_valid_i  (raw_valid),
    .ack_read_i   (ack),
    .out_key_o    (out_key),
    .key_ready_o  (key_ready),
    .intr_o       (intr),
    .health_fail_o(health_fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (intr === 1'b1) begin
      logic [N-1:0] e;
      intr_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_intr key=%h required=none", out_key);
      end else begin
        e = sb.pop_front();
        if (out_key !== e)
          $display("FAIL sb_key got=%h required=%h", out_key, e);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic a, input logic b);
    send_bit(a);
    send_bit(b);
  endtask

  task automatic send_word55();
    for (int i = 0; i < 16; i++) begin
      send_pair(1'b1, 1'b0);
      send_pair(1'b0, 1'b1);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({out_key, key_ready, intr, health_fail} !== '0)
      $display("FAIL reset_outputs got=%h/%b%b%b required=0",
               out_key, key_ready, intr, health_fail);
    else
      n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int c0;
    enable = 1'b1;
    tick(1);
    c0 = intr_cnt;
    sb.push_back(32'h5555_5555);
    send_word55();
    n_checks++;
    if (out_key !== 32'h5555_5555 || key_ready !== 1'b1 || intr !== 1'b1)
      $display("FAIL basic_latency got=%h r=%b i=%b required=55555555 1 1",
               out_key, key_ready, intr);
    else
      n_pass++;
    tick(1);
    n_checks++;
    if (intr !== 1'b0 || intr_cnt != c0 + 1)
      $display("FAIL basic_pulse got=%b cnt=%0d required=0 cnt=%0d",
               intr, intr_cnt - c0, 1);
    else
      n_pass++;
    last_key = 32'h5555_5555;
  endtask

  task automatic test_ack();
    ack_pulse();
    n_checks++;
    if (key_ready !== 1'b0)
      $display("FAIL ack_clear got=%b required=0", key_ready);
    else
      n_pass++;
    ack_pulse();
    tick(1);
    n_checks++;
    if (key_ready !== 1'b0 || out_key !== last_key)
      $display("FAIL ack_idle got=%b %h required=0 %h",
               key_ready, out_key, last_key);
    else
      n_pass++;
  endtask

  task automatic test_discard();
    sb.push_back(32'h5555_5555);
    for (int i = 0; i < 16; i++) begin
      send_pair(1'b1, 1'b0);
      send_pair(1'b0, 1'b0);
      send_pair(1'b0, 1'b1);
      send_pair(1'b1, 1'b1);
    end
    n_checks++;
    if (out_key !== 32'h5555_5555 || key_ready !== 1'b1)
      $display("FAIL discard_key got=%h r=%b required=55555555 1",
               out_key, key_ready);
    else
      n_pass++;
    ack_pulse();
  endtask

  task automatic test_stall();
    int c0;
    sb.push_back(32'h5555_5555);
    send_word55();
    sb.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) send_pair(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, 1'b1);
    tick(2);
    n_checks++;
    if (out_key !== 32'h5555_5555 || key_ready !== 1'b1)
      $display("FAIL stall_hold got=%h r=%b required=55555555 1",
               out_key, key_ready);
    else
      n_pass++;
    c0 = intr_cnt;
    ack_pulse();
    n_checks++;
    if (out_key !== 32'hFFFF_FFFF || key_ready !== 1'b1 || intr !== 1'b1)
      $display("FAIL stall_xfer got=%h r=%b i=%b required=ffffffff 1 1",
               out_key, key_ready, intr);
    else
      n_pass++;
    tick(1);
    n_checks++;
    if (intr_cnt != c0 + 1 || intr !== 1'b0)
      $display("FAIL stall_pulse got=%0d required=1", intr_cnt - c0);
    else
      n_pass++;
    last_key = 32'hFFFF_FFFF;
    ack_pulse();
    n_checks++;
    if (key_ready !== 1'b0)
      $display("FAIL stall_ack_clear got=%b required=0", key_ready);
    else
      n_pass++;
  endtask

  task automatic test_health();
    int c0;
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < 30; i++) send_bit(1'b1);
    n_checks++;
    if (health_fail !== 1'b0)
      $display("FAIL rct_early got=%b required=0", health_fail);
    else
      n_pass++;
    send_bit(1'b1);
    n_checks++;
    if (health_fail !== 1'b1 || key_ready !== 1'b0)
      $display("FAIL rct_trip got=%b r=%b required=1 0",
               health_fail, key_ready);
    else
      n_pass++;
    c0 = intr_cnt;
    send_word55();
    ack_pulse();
    tick(2);
    n_checks++;
    if (intr_cnt != c0 || out_key !== last_key || health_fail !== 1'b1)
      $display("FAIL rct_frozen got=%0d %h %b required=0 %h 1",
               intr_cnt - c0, out_key, health_fail, last_key);
    else
      n_pass++;
    enable = 1'b0;
    tick(1);
    n_checks++;
    if (health_fail !== 1'b0 || out_key !== last_key || key_ready !== 1'b0)
      $display("FAIL rct_clear got=%b %h %b required=0 %h 0",
               health_fail, out_key, key_ready, last_key);
    else
      n_pass++;
    enable = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) send_pair(1'b1, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      n_checks++;
      if ({out_key, key_ready, intr, health_fail} !== '0)
        $display("FAIL midreset_outputs got=%h/%b%b%b required=0",
                 out_key, key_ready, intr, health_fail);
      else
        n_pass++;
    end
    rst = 1'b0;
    tick(1);
    sb.push_back(32'h5555_5555);
    send_word55();
    n_checks++;
    if (out_key !== 32'h5555_5555 || key_ready !== 1'b1)
      $display("FAIL midreset_key got=%h r=%b required=55555555 1",
               out_key, key_ready);
    else
      n_pass++;
    tick(2);
  endtask

  initial begin
    last_key = '0;
    test_reset();
    test_basic();
    test_ack();
    test_discard();
    test_stall();
    test_health();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
